mem_bus_responder: RTL

Memory-side responder for the softcore's CPU memory bus: it accepts single-byte read/write requests from the control unit over a req/ack handshake, inserts a configurable number of wait states, and services them from an internal 16 KiB synchronous RAM or a small memory-mapped I/O page. Unmapped addresses are acknowledged with an error flag, so the CPU never hangs. It sits between the control unit and all storage and I/O in the system top level.

---
 rtl/mem_bus_responder_pkg.sv | 35 +++
 rtl/mem_bus_responder_bus_sram.sv | 25 ++
 rtl/mem_bus_responder.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_bus_responder_pkg.sv
// Shared constants and address decode for the CPU memory-bus responder.
package mem_bus_responder_pkg;

    // FSM state encoding: IDLE -> WAIT -> ACCESS -> CAPTURE -> ACK -> IDLE
    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StWait    = 3'd1;
    localparam logic [2:0] StAccess  = 3'd2;
    localparam logic [2:0] StCapture = 3'd3;
    localparam logic [2:0] StAck     = 3'd4;

    // Byte offsets inside the 4-byte I/O page
    localparam logic [1:0] IoGpio    = 2'd0;
    localparam logic [1:0] IoTick    = 2'd1;
    localparam logic [1:0] IoScratch = 2'd2;
    localparam logic [1:0] IoErrcnt  = 2'd3;

    // Read data returned for unmapped addresses
    localparam logic [7:0] UnmappedData = 8'hFF;

    typedef enum logic [1:0] {
        RegionRam  = 2'd0,
        RegionIo   = 2'd1,
        RegionNone = 2'd2
    } region_e;

    // RAM occupies 0 .. 2^ram_bits-1; the I/O page is matched on addr[15:2].
    function automatic region_e decode_region(input logic [15:0] addr,
                                              input int unsigned ram_bits,
                                              input logic [13:0] io_page);
        if ((32'(addr) >> ram_bits) == 32'd0) return RegionRam;
        if (addr[15:2] == io_page) return RegionIo;
        return RegionNone;
    endfunction

endpackage

// File: rtl/mem_bus_responder_bus_sram.sv
// Single-port synchronous byte RAM, one-cycle read latency (altsyncram style).
module bus_sram #(
    parameter int unsigned ADDR_BITS = 14
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] address,
    input  logic [7:0]           data,
    input  logic                 rden,
    input  logic                 wren,
    output logic [7:0]           q
);

    logic [7:0] mem [2**ADDR_BITS];

    // Write port and registered read port share one address
    always_ff @(posedge clk) begin
        if (wren) begin
            mem[address] <= data;
        end
        if (rden) begin
            q <= mem[address];
        end
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Memory-side responder: req/ack bus into RAM plus a 4-byte I/O page.
module mem_bus_responder
    import mem_bus_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_BITS = 14,
    parameter int unsigned WAIT_CYCLES   = 0,
    parameter logic [15:0] IO_BASE       = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        ack,
    output logic        err,
    output logic [7:0]  rdata,
    output logic        busy,
    output logic [7:0]  gpio_out
);

    localparam logic [13:0] IoPage   = IO_BASE[15:2];
    localparam logic [3:0]  WaitLoad = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [2:0]               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] addr_q;
    logic                     we_q;
    logic [7:0]               wdata_q;
    region_e                  region_q;
    logic [3:0]               wait_cnt_q;
    logic [7:0]               rdata_q;
    logic [7:0]               io_sample_q;
    logic [7:0]               gpio_q, scratch_q, tick_q, errcnt_q;
    logic [7:0]               io_rd_val;
    logic [7:0]               ram_q;
    logic                     ram_rden, ram_wren, io_wr, in_access;

    assign in_access = (state_q == StAccess);
    assign io_wr     = in_access && (region_q == RegionIo) && we_q;
    // Gating with reset keeps a reset in the ACCESS cycle from committing a write
    assign ram_rden  = in_access && (region_q == RegionRam) && !we_q;
    assign ram_wren  = in_access && (region_q == RegionRam) && we_q && !reset;

    bus_sram #(
        .ADDR_BITS (RAM_ADDR_BITS)
    ) u_sram (
        .clk     (clk),
        .address (addr_q),
        .data    (wdata_q),
        .rden    (ram_rden),
        .wren    (ram_wren),
        .q       (ram_q)
    );

    // Next-state logic of the transaction FSM
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:    if (req) state_d = (WAIT_CYCLES > 0) ? StWait : StAccess;
            StWait:    if (wait_cnt_q == 4'd0) state_d = StAccess;
            StAccess:  state_d = StCapture;
            StCapture: state_d = StAck;
            StAck:     state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // State register, request latch and wait-state counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            region_q   <= RegionNone;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && req) begin
                addr_q     <= addr[RAM_ADDR_BITS-1:0];
                we_q       <= we;
                wdata_q    <= wdata;
                region_q   <= decode_region(addr, RAM_ADDR_BITS, IoPage);
                wait_cnt_q <= WaitLoad;
            end else if (state_q == StWait && wait_cnt_q != 4'd0) begin
                wait_cnt_q <= wait_cnt_q - 4'd1;
            end
        end
    end

    // Read mux over the I/O page, sampled during ACCESS
    always_comb begin
        io_rd_val = 8'h00;
        case (addr_q[1:0])
            IoGpio:    io_rd_val = gpio_q;
            IoTick:    io_rd_val = tick_q;
            IoScratch: io_rd_val = scratch_q;
            IoErrcnt:  io_rd_val = errcnt_q;
            default:   io_rd_val = 8'h00;
        endcase
    end

    // I/O registers, free-running tick and saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q      <= 8'h00;
            scratch_q   <= 8'h00;
            tick_q      <= 8'h00;
            errcnt_q    <= 8'h00;
            io_sample_q <= 8'h00;
        end else begin
            tick_q <= tick_q + 8'd1;
            if (in_access) begin
                io_sample_q <= io_rd_val;
            end
            if (io_wr && addr_q[1:0] == IoGpio) gpio_q <= wdata_q;
            if (io_wr && addr_q[1:0] == IoScratch) scratch_q <= wdata_q;
            if (io_wr && addr_q[1:0] == IoErrcnt) begin
                errcnt_q <= 8'h00;
            end else if (state_q == StAck && region_q == RegionNone && errcnt_q != 8'hFF) begin
                errcnt_q <= errcnt_q + 8'd1;
            end
        end
    end

    // Read data register: loaded in CAPTURE for reads only, held otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q <= 8'h00;
        end else if (state_q == StCapture && !we_q) begin
            case (region_q)
                RegionRam: rdata_q <= ram_q;
                RegionIo:  rdata_q <= io_sample_q;
                default:   rdata_q <= UnmappedData;
            endcase
        end
    end

    assign ack      = (state_q == StAck);
    assign err      = ack && (region_q == RegionNone);
    assign busy     = (state_q != StIdle);
    assign rdata    = rdata_q;
    assign gpio_out = gpio_q;

endmodule
